// File: rtl/dequant_8b_16b.sv
// Streaming int8 -> int16 dequantizer: subtract zero point, left-shift by a
// per-frame scale, saturate to int16, two results per 32-bit output beat.
`timescale 1ns/1ps
module dequant_8b_16b (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_cfg_shift,
  input  logic [7:0]  i_cfg_zp,
  input  logic [15:0] i_cfg_len,
  input  logic        i_dat_valid,
  output logic        o_dat_ready,
  input  logic [31:0] i_dat,
  output logic        o_dat_valid,
  input  logic        i_dat_ready,
  output logic [31:0] o_dat,
  output logic        o_last,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_sat_cnt
);
  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int PROD_W = 24;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [3:0]                shift;
  logic signed [DATA_W-1:0]  zp;
  logic [15:0]               len;
  logic [15:0]               accepted;
  logic                      done;
  logic [15:0]               sat_cnt;

  logic [31:0]               dat_p0;
  logic                      vld_p0;
  logic                      half_p0;
  logic                      last_p0;

  logic [31:0]               dat_p1;
  logic                      vld_p1;
  logic                      last_p1;

  logic [DATA_W-1:0]         lane_lo;
  logic [DATA_W-1:0]         lane_hi;
  logic [OUT_W:0]            res_lo;
  logic [OUT_W:0]            res_hi;
  logic [16:0]               sat_sum;
  logic [15:0]               sat_next;
  logic                      out_load;
  logic                      out_hs;
  logic                      accept;

  // Difference of two int8 values fits 9 bits; 255 << 15 still fits 24 bits.
  function automatic logic signed [PROD_W-1:0] expand(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] z,
    input logic [3:0]               sh
  );
    logic signed [DATA_W:0]   d;
    logic signed [PROD_W-1:0] p;
    d = $signed({x[DATA_W-1], x}) - $signed({z[DATA_W-1], z});
    p = {{(PROD_W-DATA_W-1){d[DATA_W]}}, d};
    return p <<< sh;
  endfunction

  // Returns {saturated_flag, int16_value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [PROD_W-1:0] p);
    if (p > 24'sd32767)
      return {1'b1, 16'h7fff};
    else if (p < -24'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, p[OUT_W-1:0]};
  endfunction

  function automatic logic [15:0] sat_add(input logic [16:0] sum);
    return sum[16] ? 16'hffff : sum[15:0];
  endfunction

  assign lane_lo  = half_p0 ? dat_p0[23:16] : dat_p0[7:0];
  assign lane_hi  = half_p0 ? dat_p0[31:24] : dat_p0[15:8];

  always_comb begin
    res_lo = saturate(expand(lane_lo, zp, shift));
    res_hi = saturate(expand(lane_hi, zp, shift));
  end

  assign sat_sum  = 17'(sat_cnt) + 17'(res_lo[OUT_W]) + 17'(res_hi[OUT_W]);
  assign sat_next = sat_add(sat_sum);

  assign out_load    = vld_p0 && (!vld_p1 || i_dat_ready);
  assign out_hs      = vld_p1 && i_dat_ready;
  assign o_dat_ready = (state == RUN) && (accepted < len) &&
                       (!vld_p0 || (half_p0 && out_load));
  assign accept      = i_dat_valid && o_dat_ready;

  // p0: input beat buffer (data path, no reset needed)
  always_ff @(posedge i_clk) begin
    if (accept)
      dat_p0 <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      shift    <= '0;
      zp       <= '0;
      len      <= '0;
      accepted <= '0;
      done     <= 1'b0;
      sat_cnt  <= '0;
      vld_p0   <= 1'b0;
      half_p0  <= 1'b0;
      last_p0  <= 1'b0;
      dat_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == IDLE) begin
        if (i_start) begin
          shift    <= i_cfg_shift;
          zp       <= i_cfg_zp;
          len      <= i_cfg_len;
          accepted <= '0;
          sat_cnt  <= '0;
          if (i_cfg_len == 16'd0)
            done  <= 1'b1;
          else
            state <= RUN;
        end
      end else begin
        if (out_hs && last_p1) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end

      // p1: output register, loaded one half of the buffered beat at a time
      if (out_load) begin
        dat_p1  <= {res_hi[OUT_W-1:0], res_lo[OUT_W-1:0]};
        vld_p1  <= 1'b1;
        last_p1 <= half_p0 && last_p0;
        sat_cnt <= sat_next;
        if (half_p0) begin
          vld_p0  <= 1'b0;
          half_p0 <= 1'b0;
        end else begin
          half_p0 <= 1'b1;
        end
      end else if (out_hs) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end

      // A new beat overrides the buffer release of the same cycle.
      if (accept) begin
        vld_p0   <= 1'b1;
        half_p0  <= 1'b0;
        last_p0  <= ((accepted + 16'd1) == len);
        accepted <= accepted + 16'd1;
      end
    end
  end

  assign o_dat       = dat_p1;
  assign o_dat_valid = vld_p1;
  assign o_last      = last_p1;
  assign o_busy      = (state == RUN);
  assign o_done      = done;
  assign o_sat_cnt   = sat_cnt;

endmodule

// File: doc/dequant_8b_16b.md
# dequant_8b_16b

Streaming dequantizer for the NPU core datapath. It is the expand direction of the 16b→8b requantizer. It takes packed int8 activations/weights (4 per 32-bit input beat) and subtracts a zero point. It then left-shifts by a per-frame scale, saturates to int16, and emits packed int16 results (2 per 32-bit output beat). Ready/valid handshakes are used on both sides, and a frame runs for a programmed number of input beats.

## Interface
Parameters: none; all widths are fixed.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle pulse; latches the config and starts a frame; honoured only in IDLE
- i_cfg_shift  in  4  left-shift amount, 0..15, unsigned
- i_cfg_zp  in  8  zero point, signed
- i_cfg_len  in  16  input beats in the frame, unsigned
- i_dat_valid  in  1  input beat valid
- o_dat_ready  out  1  input beat accepted when i_dat_valid && o_dat_ready
- i_dat  in  32  lane k (k=0..3) = i_dat[8k+7:8k], signed int8
- o_dat_valid  out  1  output beat valid
- i_dat_ready  in  1  downstream ready
- o_dat  out  32  {result lane n+1, result lane n}, int16 each
- o_last  out  1  qualifies the final output beat of the frame
- o_busy  out  1  high in RUN
- o_done  out  1  one-cycle pulse at frame end
- o_sat_cnt  out  16  number of saturated lanes in the current/last frame

## Operation
- States are IDLE and RUN.
- IDLE→RUN on i_start. This latches shift, zp and len, and clears o_sat_cnt and the beat counter.
- If len==0, the block skips RUN and pulses o_done the next cycle.
- RUN→IDLE on the handshake of the o_last beat, with an o_done pulse the following cycle.
- i_start in RUN is ignored, and the latched config is unchanged.
- Internal input buffer:
  - Holds one 32-bit beat, with flag buf_vld and half select h (0 = lanes 0/1, 1 = lanes 2/3).
  - out_load = buf_vld && (!o_dat_valid || i_dat_ready).
  - On out_load the output register is loaded from lanes {2h+1, 2h}.
  - If h==0, h becomes 1. If h==1, buf_vld clears and h resets to 0.
- o_dat_ready = RUN && accepted < len && (!buf_vld || (h==1 && out_load)).
- An accept sets buf_vld, sets h=0 and increments accepted. Accept and free in the same cycle is legal, and the new beat wins.
- o_dat_valid clears when the beat is handshaken and no out_load occurs.
- Arithmetic per lane:
  - d = sext9(x) − sext9(zp), range −255..255.
  - p = d <<< shift, signed 24-bit.
  - The result is 32767 if p>32767, −32768 if p<−32768, else p[15:0].
  - Each saturated lane adds 1 to o_sat_cnt, which holds at 0xFFFF.
  - o_sat_cnt counts at out_load, so at most +2 per cycle.
- o_last is set with the output load of h==1 from the final (len-th) beat.
- o_dat and o_last are held stable while o_dat_valid && !i_dat_ready.

## Timing
- Reset values:
  - State IDLE; buf_vld, h and counters cleared.
  - o_dat_ready, o_dat_valid, o_last, o_busy, o_done = 0.
  - o_dat = 0, o_sat_cnt = 0.
- Latency:
  - Beat accepted at edge t.
  - First output beat is valid after edge t+1.
  - Second output beat follows after edge t+2 if downstream is ready.
- Throughput: 1 output beat/cycle sustained, which is 1 input beat every 2 cycles.
- o_busy rises the cycle after i_start. o_dat_ready can first be high that same cycle.
- o_done is asserted the cycle after the final handshake. o_busy drops with it.
- Reset mid-frame aborts immediately, and buffered and output data are discarded. No o_done is issued.
- Config ports are sampled only on i_start.

## Test plan
- Basic:
  - Stimulus: zp=0, shift=8, len=1, i_dat=0x807F0102.
  - Required: o_dat 0x01000200 then 0x80007F00; o_last on the 2nd beat; o_sat_cnt=0; o_done one cycle after.
- Saturation:
  - Stimulus: zp=0, shift=15, i_dat=0x00FF0201.
  - Required: 0x7FFF7FFF then 0x00008000; o_sat_cnt=2 (−1<<15 is exact, not saturated).
- Zero point:
  - Stimulus: zp=0x80, shift=7, i_dat=0x00007F80.
  - Required: lane0=0x0000, lane1=0x7F80 (255<<7), lane2=lane3=0x4000 (128<<7).
- Backpressure:
  - Stimulus: len=3, i_dat_ready low for 5 cycles after the 2nd output beat.
  - Required: o_dat held stable; 6 beats total in order; no drops; o_last only on the 6th.
- Edge cases:
  - len=0: o_done one cycle after i_start, no o_dat_valid.
  - i_start during RUN: ignored.
  - i_rst asserted mid-frame: all outputs at reset values next cycle.
  - A new frame after that runs correctly.
- Input gaps:
  - Stimulus: i_dat_valid toggled randomly, len=64.
  - Required: 128 output beats matching a reference model; sustained 1 beat/cycle when the input is continuous.
